// File: rtl/sr_cube_mac_unit.sv
// Multi-cycle responder computing y = a*a*b with one shift-add multiplier
// reused over two passes (a*a, then (a*a)*b); start/busy handshake.
module sr_cube_mac_unit #(
  parameter int unsigned DW = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [DW-1:0]   a_i,
  input  logic [DW-1:0]   b_i,
  input  logic            start_i,
  output logic [3*DW-1:0] y_o,
  output logic            busy_o
);

  localparam int unsigned CW = (DW > 1) ? $clog2(DW) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DW - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] MUL1 = 2'd1;
  localparam logic [1:0] MUL2 = 2'd2;

  logic [1:0]      state_q, state_d;
  logic [3*DW-1:0] mcand_q, mcand_d;
  logic [3*DW-1:0] acc_q, acc_d;
  logic [3*DW-1:0] acc_upd;
  logic [DW-1:0]   mplr_q, mplr_d;
  logic [DW-1:0]   b_q, b_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [3*DW-1:0] y_q, y_d;
  logic            busy_q, busy_d;

  assign acc_upd = acc_q + (mplr_q[0] ? mcand_q : '0);

  always_comb begin
    state_d = state_q;
    mcand_d = mcand_q;
    acc_d   = acc_q;
    mplr_d  = mplr_q;
    b_d     = b_q;
    cnt_d   = cnt_q;
    y_d     = y_q;
    busy_d  = busy_q;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          b_d     = b_i;
          mcand_d = {{(2*DW){1'b0}}, a_i};
          mplr_d  = a_i;
          acc_d   = '0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = MUL1;
        end
      end
      MUL1, MUL2: begin
        acc_d   = acc_upd;
        mcand_d = mcand_q << 1;
        mplr_d  = mplr_q >> 1;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          // Second pass reuses the datapath: a*a becomes the multiplicand, b the multiplier.
          if (state_q == MUL1) begin
            mcand_d = acc_upd;
            mplr_d  = b_q;
            acc_d   = '0;
            state_d = MUL2;
          end else begin
            y_d     = acc_upd;
            busy_d  = 1'b0;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      mcand_q <= '0;
      acc_q   <= '0;
      mplr_q  <= '0;
      b_q     <= '0;
      cnt_q   <= '0;
      y_q     <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mcand_q <= mcand_d;
      acc_q   <= acc_d;
      mplr_q  <= mplr_d;
      b_q     <= b_d;
      cnt_q   <= cnt_d;
      y_q     <= y_d;
      busy_q  <= busy_d;
    end
  end

  assign y_o    = y_q;
  assign busy_o = busy_q;

endmodule
